// File: rtl/down_counter8b_pkg.sv
// down_counter8b_pkg: shared state encoding and count width for the down-counter.
package down_counter8b_pkg;
   localparam int CNT_W = 8;
   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/decrementer8b.sv
// decrementer8b: combinational 8-bit decrement; Borrow flags wrap from zero.
module decrementer8b (
   input  logic [7:0] A,
   output logic [7:0] D,
   output logic       Borrow
);
   assign D      = A - 8'd1;
   assign Borrow = (A == 8'd0);
endmodule

// File: rtl/down_counter8b.sv
// down_counter8b: prescaled 8-bit down-counter/timer with Done pulse and optional
// auto-reload, stepping through the shared decrementer8b.
module down_counter8b
   import down_counter8b_pkg::*;
#(
   parameter int PRESCALE = 1,
   parameter int PS_W     = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             Load,
   input  logic [CNT_W-1:0] Load_Val,
   input  logic             Enable,
   input  logic             Auto_Reload,
   output logic [CNT_W-1:0] Count,
   output logic             Busy,
   output logic             Done
);
   state_t           state, state_nx;
   logic [CNT_W-1:0] reload, reload_nx, count_nx, dec;
   logic [PS_W-1:0]  ps_cnt, ps_nx;
   logic             done_nx, borrow, tick, term, reload_ok;

   decrementer8b u_dec (
      .A      (Count),
      .D      (dec),
      .Borrow (borrow)
   );

   assign Busy      = (state == RUN);
   assign tick      = Busy && Enable && (ps_cnt == PS_W'(PRESCALE - 1));
   assign term      = tick && (Count == CNT_W'(1));
   assign reload_ok = Auto_Reload && (reload != '0);

   always_comb begin
      state_nx  = state;
      count_nx  = Count;
      reload_nx = reload;
      ps_nx     = ps_cnt;
      done_nx   = 1'b0;
      if (Load) begin
         count_nx  = Load_Val;
         reload_nx = Load_Val;
         ps_nx     = '0;
         state_nx  = (Load_Val != '0) ? RUN : IDLE;
         done_nx   = (Load_Val == '0);
      end else if (Busy && Enable) begin
         ps_nx = tick ? '0 : ps_cnt + PS_W'(1);
         if (term) begin
            // reload straight from 1 so Count never shows 0 while reloading
            done_nx  = 1'b1;
            count_nx = reload_ok ? reload : '0;
            state_nx = reload_ok ? RUN : IDLE;
         end else if (tick) begin
            count_nx = dec;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         Count  <= '0;
         reload <= '0;
         ps_cnt <= '0;
         Done   <= 1'b0;
      end else begin
         state  <= state_nx;
         Count  <= count_nx;
         reload <= reload_nx;
         ps_cnt <= ps_nx;
         Done   <= done_nx;
      end
   end

   always @(posedge clk)
      if (rst_n && tick) assert (!borrow);
endmodule
